// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
//
// Multi-channel square-wave tone generator with a small memory-mapped register
// file. Each channel has a PERIOD (clk cycles per waveform period) and a
// DURATION (number of prescaler ticks to play, or "sustain" when bit 31 is set).
// A shared free-running prescaler produces one tick every TICK clk cycles.
// When a timed channel runs out it stops and latches a sticky done bit. The
// OR of the done bits drives the irq level.
//
// Register map (write strobe = cs && memwrite):
//   addr[4]=0 : channel addr[3:1], addr[0]=0 PERIOD, addr[0]=1 DURATION
//   addr=16   : STATUS  read {16'h0, done, active}, write-1-to-clear done[i]
//               through writedata[8+i]
//   other     : writes ignored, reads return 0
//
// Parameters:
//   NCH  - number of channels (1..8)
//   CW   - period / phase counter width
//   DW   - duration counter width
//   TICK - clk cycles per duration tick
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   cs         in   block select
//   memwrite   in   write strobe, qualified by cs
//   addr       in   [4:0] register address
//   writedata  in   [31:0] write data
//   readdata   out  [31:0] combinational read of STATUS (0 for other addresses)
//   ch_out     out  [NCH-1:0] per-channel square wave
//   buzz       out  OR of all ch_out bits
//   busy       out  [NCH-1:0] per-channel active flag
//   irq        out  OR of all sticky done bits
// -----------------------------------------------------------------------------
module tone_gen #(
    parameter int NCH  = 4,
    parameter int CW   = 20,
    parameter int DW   = 16,
    parameter int TICK = 62500
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            memwrite,
    input  logic [4:0]      addr,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [NCH-1:0]  ch_out,
    output logic            buzz,
    output logic [NCH-1:0]  busy,
    output logic            irq
);

    // Prescaler width; a TICK of 1 still needs a 1-bit counter.
    localparam int TCW = (TICK > 1) ? $clog2(TICK) : 1;

    localparam logic [4:0] STATUS_ADDR = 5'd16;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [TCW-1:0] r_tick_cnt;
    logic [CW-1:0]  r_period    [NCH];
    logic [CW-1:0]  r_phase     [NCH];
    logic [DW-1:0]  r_remaining [NCH];
    logic [NCH-1:0] r_sustain;
    logic [NCH-1:0] r_active;
    logic [NCH-1:0] r_done;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic           w_tick;
    logic           w_wr_en;
    logic           w_status_wr;
    logic [NCH-1:0] w_wr_per;
    logic [NCH-1:0] w_wr_dur;
    logic [NCH-1:0] w_dec;
    logic [NCH-1:0] w_fin;
    logic [NCH-1:0] w_clr;
    logic [NCH-1:0] w_audible;
    logic [CW-1:0]  w_phase_nxt [NCH];
    logic           w_dur_start;
    logic [7:0]     w_done8;
    logic [7:0]     w_active8;
    logic           w_unused;

    // Only some writedata bits carry register content; fold the whole bus
    // into one sink so partially used buses do not look like mistakes.
    assign w_unused = ^writedata;

    assign w_tick      = (r_tick_cnt == TCW'(TICK - 1));
    assign w_wr_en     = cs & memwrite;
    assign w_status_wr = w_wr_en & (addr == STATUS_ADDR);

    // A DURATION write starts the channel when it is either sustained or
    // carries a non-zero tick count; a plain zero is an immediate stop.
    assign w_dur_start = writedata[31] | (|writedata[DW-1:0]);

    // Channel write decode. Channel indices >= NCH never match, so writes
    // to unimplemented channels fall through and are ignored.
    always_comb begin
        w_wr_per = '0;
        w_wr_dur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_wr_en && !addr[4] && (addr[3:1] == 3'(i))) begin
                if (addr[0]) begin
                    w_wr_dur[i] = 1'b1;
                end else begin
                    w_wr_per[i] = 1'b1;
                end
            end
        end
    end

    // Duration countdown. A register write to the channel on the tick cycle
    // wins, so neither the decrement nor the completion happens then.
    always_comb begin
        w_dec = '0;
        w_fin = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_tick && r_active[i] && !r_sustain[i] && !w_wr_per[i] && !w_wr_dur[i]) begin
                w_dec[i] = 1'b1;
                w_fin[i] = (r_remaining[i] == DW'(1));
            end
        end
    end

    // Write-1-to-clear mask for the done bits.
    always_comb begin
        w_clr = '0;
        if (w_status_wr) begin
            w_clr = writedata[8 +: NCH];
        end
    end

    // Phase advance: wraps at period-1, held at zero whenever the channel is
    // idle, has a degenerate period (<2) or is finishing on this edge.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_phase_nxt[i] = '0;
            if (r_active[i] && !w_fin[i] && (r_period[i] >= CW'(2))) begin
                if (r_phase[i] >= (r_period[i] - CW'(1))) begin
                    w_phase_nxt[i] = '0;
                end else begin
                    w_phase_nxt[i] = r_phase[i] + CW'(1);
                end
            end
        end
    end

    // High for the first floor(period/2) phases; odd periods spend the extra
    // cycle low.
    always_comb begin
        w_audible = '0;
        for (int i = 0; i < NCH; i++) begin
            w_audible[i] = r_active[i] && (r_period[i] >= CW'(2)) &&
                           (r_phase[i] < (r_period[i] >> 1));
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler: shared, free-running
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TCW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Channel registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_period[i]    <= '0;
                r_phase[i]     <= '0;
                r_remaining[i] <= '0;
            end
            r_sustain <= '0;
            r_active  <= '0;
            r_done    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_wr_per[i]) begin
                    r_period[i] <= writedata[CW-1:0];
                    r_phase[i]  <= '0;
                end else if (w_wr_dur[i]) begin
                    r_remaining[i] <= writedata[DW-1:0];
                    r_sustain[i]   <= writedata[31];
                    r_active[i]    <= w_dur_start;
                    r_phase[i]     <= '0;
                end else begin
                    r_phase[i] <= w_phase_nxt[i];
                    if (w_dec[i]) begin
                        r_remaining[i] <= r_remaining[i] - DW'(1);
                    end
                    if (w_fin[i]) begin
                        r_active[i] <= 1'b0;
                    end
                end
            end
            // A completion on the same edge as a clear leaves the bit set.
            r_done <= (r_done & ~w_clr) | w_fin;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_done8   = '0;
        w_active8 = '0;
        w_done8[NCH-1:0]   = r_done;
        w_active8[NCH-1:0] = r_active;
    end

    assign readdata = (addr == STATUS_ADDR) ? {16'h0, w_done8, w_active8} : 32'h0;
    assign ch_out   = w_audible;
    assign buzz     = |w_audible;
    assign busy     = r_active;
    assign irq      = |r_done;

endmodule

// File: tb/tb_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_gen
//
// Bench for tone_gen with NCH=4, CW=20, DW=16, TICK=10. A cycle-level
// reference model of the register behaviour predicts the visible outputs
// for every edge; the prediction is queued when the stimulus is driven and
// compared once the edge has happened. A vector table adds hand-derived
// busy/done expectations at settled points, and short hand-written sequences
// cover waveform shape, tick collisions, set-wins and reset mid-tone.
// -----------------------------------------------------------------------------
module tb_tone_gen;

    localparam int NCH  = 4;
    localparam int CW   = 20;
    localparam int DW   = 16;
    localparam int TICK = 10;
    localparam int OW   = 42;

    // -------------------------------------------------------------------------
    // Clock / DUT
    // -------------------------------------------------------------------------
    logic           clk;
    logic           reset;
    logic           cs;
    logic           memwrite;
    logic [4:0]     addr;
    logic [31:0]    writedata;
    logic [31:0]    readdata;
    logic [NCH-1:0] ch_out;
    logic           buzz;
    logic [NCH-1:0] busy;
    logic           irq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tone_gen #(
        .NCH  (NCH),
        .CW   (CW),
        .DW   (DW),
        .TICK (TICK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .ch_out    (ch_out),
        .buzz      (buzz),
        .busy      (busy),
        .irq       (irq)
    );

    // -------------------------------------------------------------------------
    // Counters and scoreboard
    // -------------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    logic [OW-1:0] exp_q[$];

    // Reference model state
    int       m_period [NCH];
    int       m_phase  [NCH];
    int       m_rem    [NCH];
    logic [3:0] m_sus  = '0;
    logic [3:0] m_act  = '0;
    logic [3:0] m_done = '0;
    int       m_tc     = 0;
    int       m_ticks  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic cs_i, input logic we_i,
                              input logic [4:0] a, input logic [31:0] d);
        logic       tick;
        logic [3:0] fin;
        logic [3:0] clr;
        logic       was_act;
        logic       hit;
        fin = '0;
        clr = '0;
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_period[ch] = 0;
                m_phase[ch]  = 0;
                m_rem[ch]    = 0;
            end
            m_sus  = '0;
            m_act  = '0;
            m_done = '0;
            m_tc   = 0;
        end else begin
            tick = (m_tc == TICK - 1);
            m_tc = tick ? 0 : m_tc + 1;
            if (tick) m_ticks++;
            for (int ch = 0; ch < NCH; ch++) begin
                hit = cs_i && we_i && !a[4] && (int'(a[3:1]) == ch);
                if (hit && !a[0]) begin
                    m_period[ch] = int'(d[19:0]);
                    m_phase[ch]  = 0;
                end else if (hit && a[0]) begin
                    m_rem[ch]   = int'(d[15:0]);
                    m_sus[ch]   = d[31];
                    m_act[ch]   = d[31] || (d[15:0] != 16'h0);
                    m_phase[ch] = 0;
                end else begin
                    was_act = m_act[ch];
                    if (tick && m_act[ch] && !m_sus[ch]) begin
                        if (m_rem[ch] == 1) begin
                            m_act[ch] = 1'b0;
                            fin[ch]   = 1'b1;
                        end
                        m_rem[ch] = m_rem[ch] - 1;
                    end
                    if (was_act && !fin[ch] && m_period[ch] >= 2)
                        m_phase[ch] = (m_phase[ch] + 1) % m_period[ch];
                    else
                        m_phase[ch] = 0;
                end
            end
            if (cs_i && we_i && a == 5'd16) clr = d[11:8];
            m_done = (m_done & ~clr) | fin;
        end
    endtask

    function automatic logic [OW-1:0] model_obs(input logic [4:0] a);
        logic [3:0]  co;
        logic [31:0] st;
        for (int ch = 0; ch < NCH; ch++)
            co[ch] = m_act[ch] && (m_period[ch] >= 2) && (m_phase[ch] < m_period[ch] / 2);
        st = {16'h0, 4'h0, m_done, 4'h0, m_act};
        return {co, |co, m_act, |m_done, (a == 5'd16) ? st : 32'h0};
    endfunction

    task automatic check_obs();
        logic [OW-1:0] exp;
        logic [OW-1:0] got;
        got = {ch_out, buzz, busy, irq, readdata};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got %0h with no expected entry", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_err++;
                $display("FAIL outputs {ch_out,buzz,busy,irq,readdata} t=%0t: got %0h expected %0h",
                         $time, got, exp);
            end
        end
    endtask

    // One clock cycle: drive, predict, let the edge happen, compare.
    task automatic drive(input logic rst, input logic cs_i, input logic we_i,
                         input logic [4:0] a, input logic [31:0] d);
        reset     = rst;
        cs        = cs_i;
        memwrite  = we_i;
        addr      = a;
        writedata = d;
        model_edge(rst, cs_i, we_i, a, d);
        exp_q.push_back(model_obs(a));
        @(posedge clk);
        #1;
        check_obs();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd16, 32'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, 1'b1, a, d);
    endtask

    // Idle until the next edge is a prescaler tick.
    task automatic wait_tick_next();
        for (int k = 0; k < TICK && m_tc != TICK - 1; k++) idle();
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        cs;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          idle;
        logic [3:0]  exp_busy;
        logic [3:0]  exp_done;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic c, input logic w,
                                input logic [4:0] a, input logic [31:0] d,
                                input int n, input logic [3:0] eb, input logic [3:0] ed);
        vec_t v;
        v.rst = rst; v.cs = c; v.we = w; v.addr = a; v.data = d;
        v.idle = n; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    initial begin
        vec_t       vecs [24];
        logic [15:0] pat;
        logic [9:0]  pat5;
        int          t0;

        reset = 1'b1; cs = 1'b0; memwrite = 1'b0; addr = 5'd16; writedata = 32'h0;
        #2;

        vecs[0]  = mk(1, 0, 0, 5'd16, 32'h0,          2,    4'h0, 4'h0); // reset
        vecs[1]  = mk(0, 1, 1, 5'd0,  32'd8,          2,    4'h0, 4'h0); // ch0 period 8
        vecs[2]  = mk(0, 1, 1, 5'd1,  32'd3,          45,   4'h0, 4'h1); // ch0 3 ticks
        vecs[3]  = mk(0, 1, 1, 5'd2,  32'd5,          1,    4'h0, 4'h1); // ch1 period 5
        vecs[4]  = mk(0, 1, 1, 5'd3,  32'd2,          25,   4'h0, 4'h3); // ch1 2 ticks
        vecs[5]  = mk(0, 1, 1, 5'd16, 32'h100,        1,    4'h0, 4'h2); // W1C bit 0
        vecs[6]  = mk(0, 1, 1, 5'd16, 32'h200,        1,    4'h0, 4'h0); // W1C bit 1
        vecs[7]  = mk(0, 1, 1, 5'd4,  32'd1,          1,    4'h0, 4'h0); // ch2 period 1
        vecs[8]  = mk(0, 1, 1, 5'd5,  32'd2,          5,    4'h4, 4'h0); // ch2 silent, busy
        vecs[9]  = mk(0, 0, 0, 5'd16, 32'h0,          25,   4'h0, 4'h4);
        vecs[10] = mk(0, 1, 1, 5'd6,  32'd0,          1,    4'h0, 4'h4); // ch3 period 0
        vecs[11] = mk(0, 1, 1, 5'd7,  32'd2,          30,   4'h0, 4'hC);
        vecs[12] = mk(0, 0, 1, 5'd1,  32'd5,          2,    4'h0, 4'hC); // no cs
        vecs[13] = mk(0, 1, 0, 5'd1,  32'd5,          2,    4'h0, 4'hC); // no memwrite
        vecs[14] = mk(0, 1, 1, 5'd11, 32'd3,          2,    4'h0, 4'hC); // ch5 absent
        vecs[15] = mk(0, 1, 1, 5'd20, 32'hF00,        2,    4'h0, 4'hC); // unmapped
        vecs[16] = mk(0, 1, 1, 5'd16, 32'hF00,        1,    4'h0, 4'h0);
        vecs[17] = mk(0, 1, 1, 5'd0,  32'd6,          1,    4'h0, 4'h0);
        vecs[18] = mk(0, 1, 1, 5'd1,  32'h8000_0000,  1100, 4'h1, 4'h0); // sustain
        vecs[19] = mk(0, 1, 1, 5'd1,  32'h0,          2,    4'h0, 4'h0); // stop
        vecs[20] = mk(0, 1, 1, 5'd0,  32'd8,          1,    4'h0, 4'h0);
        vecs[21] = mk(0, 1, 1, 5'd4,  32'd6,          1,    4'h0, 4'h0);
        vecs[22] = mk(0, 1, 1, 5'd1,  32'd50,         1,    4'h1, 4'h0);
        vecs[23] = mk(0, 1, 1, 5'd5,  32'd50,         30,   4'h5, 4'h0); // ch0+ch2

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].data);
            repeat (vecs[i].idle) idle();
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d done", i), 64'(readdata[11:8]), 64'(vecs[i].exp_done));
        end

        // Basic tone: period 8 gives 4 high / 4 low, done after the 3rd tick.
        wr(5'd0, 32'd8);
        wr(5'd1, 32'd3);
        t0     = m_ticks;
        pat[0] = ch_out[0];
        for (int k = 1; k < 16; k++) begin
            idle();
            pat[k] = ch_out[0];
        end
        check("period8 pattern", 64'(pat), 64'h0F0F);
        for (int k = 0; k < 40 && busy[0]; k++) idle();
        check("basic busy drop", 64'(busy[0]), 64'h0);
        check("basic tick count", 64'(m_ticks - t0), 64'd3);
        check("basic done", 64'(readdata[8]), 64'h1);
        check("basic irq", 64'(irq), 64'h1);

        // Odd period 5: 2 high / 3 low.
        wr(5'd2, 32'd5);
        wr(5'd3, 32'd20);
        pat5[0] = ch_out[1];
        for (int k = 1; k < 10; k++) begin
            idle();
            pat5[k] = ch_out[1];
        end
        check("period5 pattern", 64'(pat5), 64'h063);

        // Collision: DURATION=5 written on the tick that would end the tone.
        wr(5'd6, 32'd4);
        wr(5'd16, 32'h800);
        wr(5'd7, 32'd2);
        wait_tick_next();
        idle();
        wait_tick_next();
        wr(5'd7, 32'd5);
        idle();
        check("collision no done", 64'(readdata[11]), 64'h0);
        check("collision busy", 64'(readdata[3]), 64'h1);
        repeat (44) idle();
        check("collision 4 ticks busy", 64'(busy[3]), 64'h1);
        repeat (10) idle();
        check("collision 5 ticks busy", 64'(busy[3]), 64'h0);
        check("collision 5 ticks done", 64'(readdata[11]), 64'h1);

        // Set wins: clear done[0] on the same edge that completes ch0.
        wr(5'd16, 32'h100);
        wr(5'd1, 32'd1);
        wait_tick_next();
        wr(5'd16, 32'h100);
        check("set wins done", 64'(readdata[8]), 64'h1);
        check("set wins busy", 64'(busy[0]), 64'h0);

        // Reset mid-tone.
        check("pre-reset irq", 64'(irq), 64'h1);
        check("pre-reset busy", 64'(busy[2] | busy[1]), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 5'd16, 32'h0);
        check("reset ch_out", 64'(ch_out), 64'h0);
        check("reset buzz", 64'(buzz), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset irq", 64'(irq), 64'h0);
        check("reset readdata", 64'(readdata), 64'h0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter NCH, default 4, SHALL set the number of tone channels; the legal range is 1..8.
REQ-003 Parameter CW, default 20, SHALL set the period and phase counter width in bits.
REQ-004 Parameter DW, default 16, SHALL set the duration counter width in bits.
REQ-005 Parameter TICK, default 62500, SHALL set the clk cycles per duration tick (1 ms at 62.5 MHz).
REQ-006 Port clk, input, 1 bit: system clock.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port cs, input, 1 bit: block select.
REQ-009 Port memwrite, input, 1 bit: write strobe, qualified by cs.
REQ-010 Port addr, input, 5 bits: register address.
REQ-011 Port writedata, input, 32 bits: write data.
REQ-012 Port readdata, output, 32 bits: combinational status read.
REQ-013 Port ch_out, output, NCH bits: per-channel square wave.
REQ-014 Port buzz, output, 1 bit: OR of all ch_out bits.
REQ-015 Port busy, output, NCH bits: per-channel active flag.
REQ-016 Port irq, output, 1 bit: level, equal to the OR of all sticky done bits.

Function
REQ-017 Address map: for addr[4]=0, addr[3:1] SHALL select the channel; addr[0]=0 SHALL select PERIOD and addr[0]=1 SHALL select DURATION. addr=16 SHALL be STATUS.
REQ-018 A write SHALL occur only when cs && memwrite are both 1 in a cycle; writes to a channel index >= NCH, and to addresses 17..31, SHALL be ignored.
REQ-019 A PERIOD write SHALL set period[ch] <= writedata[CW-1:0] and clear phase[ch] to 0 in the same edge.
REQ-020 A DURATION write SHALL set remaining[ch] <= writedata[DW-1:0] and sustain[ch] <= writedata[31], and clear phase[ch] to 0.
REQ-021 After a DURATION write, active[ch] SHALL be 1 if writedata[31]=1 or writedata[DW-1:0]!=0; otherwise it SHALL be 0 (immediate stop, no done event).
REQ-022 Phase counter: while active[ch]=1 and period[ch]>=2, phase SHALL advance each cycle, wrapping from period-1 to 0; otherwise phase SHALL hold at 0.
REQ-023 ch_out[ch] SHALL be 1 exactly when active=1, period>=2 and phase < (period>>1) — i.e. registered phase compared combinationally. Odd periods therefore give floor(P/2) cycles high.
REQ-024 Prescaler: tick_cnt SHALL count 0..TICK-1 and wrap; tick SHALL be high for one cycle when tick_cnt==TICK-1. The prescaler is shared by all channels and free-running.
REQ-025 On tick, each channel with active=1 and sustain=0 SHALL decrement remaining by 1.
REQ-026 On a tick where remaining==1, that channel SHALL clear active and set done[ch]=1 at the same edge.
REQ-027 A DURATION or PERIOD write to a channel in the same cycle as its tick SHALL take priority; no decrement and no done event for that channel that cycle.
REQ-028 STATUS read SHALL return {16'h0, 8'(done), 8'(active)}, zero-extended above NCH; a read of any other address SHALL return 0.
REQ-029 A STATUS write SHALL clear done[i] wherever writedata[8+i]=1 (write-1-to-clear).
REQ-030 A done set and a clear on the same channel in the same cycle SHALL leave done=1 (set wins).
REQ-031 busy SHALL equal active.
REQ-032 A sustained channel SHALL play until its DURATION is rewritten; it SHALL never set done.

Reset
REQ-033 On reset=1 at a clock edge: period, phase, remaining, sustain, active, done and tick_cnt SHALL all be 0.
REQ-034 During and after reset: ch_out=0, buzz=0, busy=0, irq=0, and a STATUS read SHALL return 0.
REQ-035 Reset asserted mid-tone SHALL silence the channel at that edge without setting done.

Verification
REQ-036 Scenario — basic tone: TICK=10; write PERIOD ch0=8, then DURATION ch0=3 → ch_out[0] is 4 high / 4 low per period. After the 3rd tick, busy[0]=0, done[0]=1, irq=1.
REQ-037 Scenario — odd and degenerate periods: PERIOD=5 → 2 high / 3 low. PERIOD=1 or 0 with DURATION=2 → ch_out stays 0, and busy stays 1 until done.
REQ-038 Scenario — collision: DURATION write of 5 in the same cycle as a tick, while remaining==1 → no done; remaining=5.
REQ-039 Scenario — W1C and set-wins: with done=4'b0011, write STATUS with bit 8 set → done=4'b0010. A clear in the same cycle as a completion → bit stays 1.
REQ-040 Scenario — sustain and stop: DURATION=32'h8000_0000 → tone continues past 100 ticks. A later DURATION=0 → ch_out=0 next cycle, done unchanged.
REQ-041 Scenario — multi-channel and reset: NCH=4, channels 0 and 2 playing → buzz=ch_out[0]|ch_out[2]. Assert reset mid-tone → all outputs 0 and readdata=0 after one edge.
